// File: rtl/hb_decim_seq.sv
// Time-multiplexed 27-tap Q15 half-band decimator: one shared multiplier, 8 MAC steps per output.
// Optional output saturation with sat pulse when HB_SAT_EN is defined; default build wraps.
module hb_decim_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic        sat
);

    localparam int unsigned DW   = 16;
    localparam int unsigned NTAP = 27;
    localparam int unsigned PW   = 5;
    localparam int unsigned SW   = 17;
    localparam int unsigned MW   = 33;
    localparam int unsigned AW   = 36;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                r_state, w_state_nxt;
    logic [DW-1:0]         r_buf [NTAP];
    logic [PW-1:0]         r_wp, w_wp_nxt;
    logic                  r_phase, w_phase_nxt;
    logic [2:0]            r_step, w_step_nxt;
    logic signed [AW-1:0]  r_acc, w_acc_nxt;
    logic                  r_in_ready, w_in_ready_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic [DW-1:0]         r_out_data, w_out_data_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_sat, w_sat_nxt;
    logic                  w_we;

    logic signed [6:0]     w_wp_s, w_two_s;
    logic [PW-1:0]         w_idx_a, w_idx_b, w_idx_c;
    logic [DW-1:0]         w_tap_a, w_tap_b, w_tap_c;
    logic signed [SW-1:0]  w_pair, w_mul_a;
    logic signed [DW-1:0]  w_coef;
    logic signed [MW-1:0]  w_prod;
    logic signed [AW-1:0]  w_acc_sum;
    logic [DW-1:0]         w_res;
    logic                  w_clip;

    // Wrap a small signed offset from wp back into 0..26
    function automatic logic [PW-1:0] f_mod27(input logic signed [6:0] v);
        logic signed [6:0] t;
        t = v;
        if (t < 7'sd0)
            t = t + 7'sd27;
        else if (t >= 7'sd27)
            t = t - 7'sd27;
        return PW'(t);
    endfunction

    // wp already points past the newest sample: tap[2s] = wp-1-2s, tap[26-2s] = wp+2s, tap[13] = wp-14
    always_comb begin
        w_wp_s  = $signed({2'b00, r_wp});
        w_two_s = $signed({3'b000, r_step, 1'b0});
        w_idx_a = f_mod27(w_wp_s - 7'sd1 - w_two_s);
        w_idx_b = f_mod27(w_wp_s + w_two_s);
        w_idx_c = f_mod27(w_wp_s - 7'sd14);
    end

    assign w_tap_a = r_buf[w_idx_a];
    assign w_tap_b = r_buf[w_idx_b];
    assign w_tap_c = r_buf[w_idx_c];

    always_comb begin
        case (r_step)
            3'd0:    w_coef = 16'sd4;
            3'd1:    w_coef = -16'sd29;
            3'd2:    w_coef = 16'sd131;
            3'd3:    w_coef = -16'sd421;
            3'd4:    w_coef = 16'sd1114;
            3'd5:    w_coef = -16'sd2785;
            3'd6:    w_coef = 16'sd10179;
            default: w_coef = 16'sd16384;
        endcase
    end

    // Shared datapath: symmetric pair sum, or the centre tap on the last step
    always_comb begin
        w_pair    = $signed({w_tap_a[DW-1], w_tap_a}) + $signed({w_tap_b[DW-1], w_tap_b});
        w_mul_a   = (r_step == 3'd7) ? $signed({w_tap_c[DW-1], w_tap_c}) : w_pair;
        w_prod    = MW'(w_mul_a) * MW'(w_coef);
        w_acc_sum = r_acc + AW'(w_prod);
    end

`ifdef HB_SAT_EN
    logic signed [20:0] w_shift;

    always_comb begin
        w_shift = 21'(w_acc_sum >>> 15);
        w_clip  = 1'b0;
        w_res   = w_shift[DW-1:0];
        if (w_shift > 21'sd32767) begin
            w_res  = 16'h7FFF;
            w_clip = 1'b1;
        end else if (w_shift < -21'sd32768) begin
            w_res  = 16'h8000;
            w_clip = 1'b1;
        end
    end
`else
    assign w_res  = w_acc_sum[30:15];
    assign w_clip = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_wp_nxt        = r_wp;
        w_phase_nxt     = r_phase;
        w_step_nxt      = r_step;
        w_acc_nxt       = r_acc;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_sat_nxt       = 1'b0;
        w_we            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_we        = 1'b1;
                    w_wp_nxt    = (r_wp == PW'(NTAP - 1)) ? '0 : r_wp + 5'd1;
                    w_phase_nxt = ~r_phase;
                    if (r_phase) begin
                        w_acc_nxt   = '0;
                        w_step_nxt  = '0;
                        w_state_nxt = S_MAC;
                    end
                end
            end
            S_MAC: begin
                if (r_step == 3'd7) begin
                    w_out_data_nxt  = w_res;
                    w_sat_nxt       = w_clip;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_OUT;
                end else begin
                    w_acc_nxt  = w_acc_sum;
                    w_step_nxt = r_step + 3'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_in_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wp        <= '0;
            r_phase     <= 1'b0;
            r_step      <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_sat       <= 1'b0;
            for (int i = 0; i < NTAP; i++) r_buf[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wp        <= w_wp_nxt;
            r_phase     <= w_phase_nxt;
            r_step      <= w_step_nxt;
            r_acc       <= w_acc_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_busy      <= w_busy_nxt;
            r_sat       <= w_sat_nxt;
            if (w_we) r_buf[r_wp] <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign sat       = r_sat;

endmodule

// File: tb/tb_hb_decim_seq.sv
// Bench for hb_decim_seq: impulse tables, DC/random data against a direct-form model, handshake corners.
module tb_hb_decim_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        sat;

    hb_decim_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        s;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[23];
    int          h[27];
    int          hist[27];
    bit          phase;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_count = 0;
    logic        prev_ov  = 1'b0;
    logic [15:0] last_out = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 27; k++) hist[k] = 0;
        phase = 1'b0;
    endtask

    // Direct-form convolution over the newest 27 samples
    task automatic model_accept(input logic [15:0] d, input bit use_tab, input logic [15:0] tab);
        longint acc;
        longint y;
        exp_t   e;
        for (int k = 26; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'($signed(d));
        if (phase) begin
            acc = 0;
            for (int k = 0; k < 27; k++) acc += longint'(h[k]) * longint'(hist[k]);
            y      = acc >>> 15;
            e.s    = 1'b0;
            e.data = 16'(y);
`ifdef HB_SAT_EN
            if (y > 32767) begin
                e.data = 16'h7FFF;
                e.s    = 1'b1;
            end else if (y < -32768) begin
                e.data = 16'h8000;
                e.s    = 1'b1;
            end
`endif
            if (use_tab) begin
                e.data = tab;
                e.s    = 1'b0;
            end
            sb_q.push_back(e);
        end
        phase = ~phase;
    endtask

    task automatic send(input logic [15:0] d, input bit use_tab, input logic [15:0] tab);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            model_accept(d, use_tab, tab);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Scoreboard: pop on every completed output transfer
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (out_valid && !prev_ov && sb_q.size() > 0)
                chk("sat_pulse", 32'(sat), 32'(sb_q[0].s));
            if (out_valid && out_ready) begin
                hs_count++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none", out_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    last_out = out_data;
                end
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          odd_exp[15] = '{3, -29, 130, -421, 1113, -2785, 10178, 10178,
                                     -2785, 1113, -421, 130, -29, 3, 0};
        int          w[7]        = '{4, -29, 131, -421, 1114, -2785, 10179};
        logic [15:0] steady;
        logic [15:0] x;
        bit          ok;
        int          n;
        int          hs0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        for (int k = 0; k < 27; k++) h[k] = 0;
        for (int i = 0; i < 7; i++) begin
            h[2*i]      = w[i];
            h[26 - 2*i] = w[i];
        end
        h[13] = 16384;
        model_reset();

        for (int i = 0; i < 15; i++) begin
            vecs[i].a   = 16'd0;
            vecs[i].b   = (i == 0) ? 16'd32767 : 16'd0;
            vecs[i].exp = 16'(odd_exp[i]);
        end
        for (int j = 0; j < 8; j++) begin
            vecs[15 + j].a   = (j == 0) ? 16'd32767 : 16'd0;
            vecs[15 + j].b   = 16'd0;
            vecs[15 + j].exp = (j == 6) ? 16'd16383 : 16'd0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Odd- and even-phase impulse tables
        for (int i = 0; i < 23; i++) begin
            send(vecs[i].a, 1'b0, 16'd0);
            send(vecs[i].b, 1'b1, vecs[i].exp);
        end
        drain();

        // DC full scale
        for (int i = 0; i < 40; i++) send(16'd32767, 1'b0, 16'd0);
        drain();
`ifdef HB_SAT_EN
        steady = 16'h7FFF;
`else
        steady = 16'h8000;
`endif
        chk("dc_steady", 32'(last_out), 32'(steady));

        // Random data
        for (int i = 0; i < 30; i++) send(16'($urandom), 1'b0, 16'd0);
        drain();

        // Backpressure: hold 20 cycles, offered input must be ignored
        out_ready = 1'b0;
        send(16'($urandom), 1'b0, 16'd0);
        send(16'($urandom), 1'b0, 16'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        ok = (sb_q.size() == 1);
        x  = ok ? sb_q[0].data : 16'd0;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int i = 0; i < 20; i++) begin
            if (out_data !== x || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_hold_stable", 32'(ok), 32'd1);
        hs0 = hs_count;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_one_transfer", 32'(hs_count), 32'(hs0 + 1));

        // Latency: accept at E0, out_valid after E8, busy through OUT
        send(16'($urandom), 1'b0, 16'd0);
        send(16'($urandom), 1'b0, 16'd0);
        for (int k = 0; k < 8; k++) begin
            chk("lat_busy_pre", 32'({busy, out_valid, in_ready}), 32'b100);
            @(negedge clk);
        end
        chk("lat_valid_e8", 32'({busy, out_valid}), 32'b11);
        @(negedge clk);
        chk("lat_idle_after", 32'({busy, out_valid, in_ready}), 32'b001);
        drain();

        // Reset during MAC step 4
        send(16'd1000, 1'b0, 16'd0);
        send(16'd2000, 1'b0, 16'd0);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].a, 1'b0, 16'd0);
            send(vecs[i].b, 1'b1, vecs[i].exp);
        end
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
